instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Front-end stage upstream of instruction decode. Holds the program counter and issues word fetches to instruction memory over a valid/ready request channel. Buffers returned instruction words in a small in-order queue and presents them, with their PC, to decode over a valid/ready channel. A redirect from execute (branch/jump) flushes the queue and discards in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset; bits [1:0] must be 0.
- `DEPTH`, default 2: instruction queue entries; also the cap on outstanding requests; power of two, ≥2.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low; sampled on rising `clk`.
- `redirect_valid`  in  1  load new PC this cycle.
- `redirect_pc`  in  32  target; bits [1:0] ignored (treated as 0).
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  word address (byte address, [1:0]=0).
- `imem_req_ready`  in  1  memory accepts request.
- `imem_rsp_valid`  in  1  response word valid; no backpressure.
- `imem_rsp_data`  in  32  instruction word.
- `instr_valid`  out  1  queue head valid.
- `instr`  out  32  queue head instruction, feeds decode `instr`.
- `instr_pc`  out  32  PC of queue head.
- `instr_ready`  in  1  decode consumes head.

## Operation
- State: `pc`, `outstanding` (requests accepted, response pending; 0..DEPTH), `drop_cnt` (stale responses to discard), queue of {pc, instr}, `count`.
- FSM: RESET (first cycle after `reset` high; no request) → RUN. RUN → FLUSH on redirect with outstanding>0 (after update). FLUSH → RUN when `drop_cnt` reaches 0. In FLUSH, new requests are allowed; the state only governs discard.
- Request: `imem_req_valid` = state≠RESET && !redirect_valid && (outstanding + count) < DEPTH. `imem_req_addr` = `pc`. On handshake: `pc` += 4 (wraps 32'hFFFF_FFFC → 0), outstanding += 1.
- Response: outstanding -= 1. If `drop_cnt`>0 or redirect_valid the same cycle: discard; else push {PC of that request, data}. Request PCs are tracked in a DEPTH-entry in-order tag queue.
- Redirect: `pc` ← {redirect_pc[31:2],2'b00}; queue cleared; `drop_cnt` ← outstanding after this cycle's request/response updates; a response arriving that cycle is discarded and not counted.
- Pop: `instr_valid` && `instr_ready` && !redirect_valid removes head.
- Credit rule guarantees no queue overflow; a response with outstanding==0 is a protocol error (assertion), ignored.
- Reset values: `pc`=RESET_PC, outstanding=0, drop_cnt=0, count=0, `imem_req_valid`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, state=RESET. Reset mid-operation discards everything; later responses to pre-reset requests are the memory's responsibility (it resets too).

## Timing
- Request accepted cycle N → response earliest N+1 → `instr_valid` earliest N+2 (registered queue, no bypass).
- Steady state with 1-cycle memory and `instr_ready`=1: one instruction per cycle.
- Redirect in cycle R: first request to target issued in R+1 if credits allow; earlier responses never reach decode.
- `imem_req_valid` is combinational on `redirect_valid`; all other outputs are registered.

## Structure
- `types.svh`: `fetch_state_t` enum {RESET, RUN, FLUSH}; `fetch_entry_t` struct {pc, instr}.
- `params.vh`: `RESET_PC` default constant, `INSTR_BYTES` = 4.
- Sub-module `fetch_queue`: synchronous in-order FIFO parameterised by width/DEPTH with push, pop, flush, count; instantiated twice (tag queue, instruction queue).

## Test plan
- Reset then `imem_req_ready`=1, 1-cycle memory returning addr^32'hA5A5_0000 → requests 0,4,8,…; `instr_pc`/`instr` match in order, first `instr_valid` at cycle 3 after reset release.
- `instr_ready`=0 for 10 cycles → exactly DEPTH requests issued, then `imem_req_valid`=0; release → entries 0,4 drain, fetch resumes at 8.
- Redirect to 32'h0000_0103 with 2 outstanding → next request addr 32'h0000_0100; both stale responses discarded; first `instr_pc`=32'h100.
- Redirect coinciding with a response and a pop → response dropped, queue empty next cycle, `imem_req_valid`=0 in redirect cycle.
- RESET_PC=32'hFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `reset` low mid-stream with full queue → next cycle `instr_valid`=0, `imem_req_valid`=0, `pc`=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instruction_fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          INSTR_BYTES      = 4;

    typedef enum logic [1:0] {
        FETCH_RESET,
        FETCH_RUN,
        FETCH_FLUSH
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small in-order FIFO with registered storage; the head is read directly from
// the storage flops, so a pushed entry becomes visible the cycle after the push.
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;
    logic [DEPTH-1:0] wr_en;

    always_comb begin
        do_push  = push && (count_q != CW'(DEPTH));
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = do_push && !flush && (wr_ptr_q == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) mem_q[i] <= push_data;
            end
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, credit-limited request issue, PC tag tracking and
// an instruction queue toward decode, with redirect-driven flush of stale data.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] instr_count, tag_count;
    logic [CW:0]   credits_used;
    logic [31:0]   tag_pc;
    fetch_entry_t  push_entry, head_entry;
    logic          req_fire, rsp_take, rsp_push, instr_pop;

    always_comb begin
        // Queued plus in-flight words may never exceed the queue depth.
        credits_used   = {1'b0, outstanding_q} + {1'b0, instr_count};
        imem_req_valid = (state_q != FETCH_RESET) && !redirect_valid
                         && (credits_used < (CW+1)'(DEPTH));
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_take       = imem_rsp_valid && (outstanding_q != '0);
        rsp_push       = rsp_take && (drop_cnt_q == '0) && !redirect_valid;
        instr_pop      = instr_valid && instr_ready && !redirect_valid;
        push_entry.pc    = tag_pc;
        push_entry.instr = imem_rsp_data;

        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);

        pc_d = pc_q;
        if (redirect_valid) pc_d = {redirect_pc[31:2], 2'b00};
        else if (req_fire)  pc_d = pc_q + 32'(INSTR_BYTES);

        // Everything still in flight after a redirect belongs to the old path.
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid)                      drop_cnt_d = outstanding_d;
        else if (rsp_take && drop_cnt_q != '0)   drop_cnt_d = drop_cnt_q - CW'(1);

        state_d = state_q;
        case (state_q)
            FETCH_RESET: state_d = FETCH_RUN;
            default:     state_d = (drop_cnt_d != '0) ? FETCH_FLUSH : FETCH_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= FETCH_RESET;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!imem_rsp_valid || outstanding_q != '0);
            assert (tag_count == outstanding_q);
        end
    end

    // Tag queue keeps running across redirects so stale responses still pop their PC.
    fetch_queue #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (rsp_take),
        .head_data (tag_pc),
        .count     (tag_count)
    );

    fetch_queue #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (rsp_push),
        .push_data (push_entry),
        .pop       (instr_pop),
        .head_data (head_entry),
        .count     (instr_count)
    );

    assign imem_req_addr = pc_q;
    assign instr_valid   = (instr_count != '0);
    assign instr         = head_entry.instr;
    assign instr_pc      = head_entry.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a default-PC instance plus one reset to
// 32'hFFFF_FFF8, each paired with a one-cycle instruction memory model.
module tb_instruction_fetch;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        mem_hold;

    logic        hi_redirect_valid;
    logic [31:0] hi_redirect_pc;
    logic        hi_req_valid;
    logic [31:0] hi_req_addr;
    logic        hi_req_ready;
    logic        hi_rsp_valid;
    logic [31:0] hi_rsp_data;
    logic        hi_instr_valid;
    logic [31:0] hi_instr;
    logic [31:0] hi_instr_pc;
    logic        hi_instr_ready;

    int checks = 0;
    int errors = 0;
    int fires;

    logic [31:0] pend[$];
    logic [31:0] hi_pend[$];

    instruction_fetch u_dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_dut_hi (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (hi_redirect_valid),
        .redirect_pc    (hi_redirect_pc),
        .imem_req_valid (hi_req_valid),
        .imem_req_addr  (hi_req_addr),
        .imem_req_ready (hi_req_ready),
        .imem_rsp_valid (hi_rsp_valid),
        .imem_rsp_data  (hi_rsp_data),
        .instr_valid    (hi_instr_valid),
        .instr          (hi_instr),
        .instr_pc       (hi_instr_pc),
        .instr_ready    (hi_instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle memory; mem_hold parks accepted requests until released.
    always @(posedge clk) begin
        if (!reset) begin
            pend.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready) pend.push_back(imem_req_addr);
            if (!mem_hold && pend.size() > 0) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= pend.pop_front() ^ KEY;
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            hi_pend.delete();
            hi_rsp_valid <= 1'b0;
            hi_rsp_data  <= '0;
        end else begin
            if (hi_req_valid && hi_req_ready) hi_pend.push_back(hi_req_addr);
            if (hi_pend.size() > 0) begin
                hi_rsp_valid <= 1'b1;
                hi_rsp_data  <= hi_pend.pop_front() ^ KEY;
            end else begin
                hi_rsp_valid <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a negedge with instr_ready=1; leaves after the head has been popped.
    task automatic wait_instr(input string tag, input logic [31:0] exp_pc);
        for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_pc"}, instr_pc, exp_pc);
        check({tag, "_instr"}, instr, exp_pc ^ KEY);
        $display("instr %s: pc=%h instr=%h", tag, instr_pc, instr);
        @(negedge clk);
    endtask

    task automatic wait_hi(input string tag, input logic [31:0] exp_pc);
        for (int i = 0; i < 20 && !hi_instr_valid; i++) @(negedge clk);
        check({tag, "_valid"}, 32'(hi_instr_valid), 32'd1);
        check({tag, "_pc"}, hi_instr_pc, exp_pc);
        check({tag, "_instr"}, hi_instr, exp_pc ^ KEY);
        $display("hi instr %s: pc=%h instr=%h", tag, hi_instr_pc, hi_instr);
        @(negedge clk);
    endtask

    // Holds reset for three edges and releases it on a negedge.
    task automatic do_reset(input logic ready);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = ready;
        mem_hold       = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset             = 1'b0;
        redirect_valid    = 1'b0;
        redirect_pc       = '0;
        imem_req_ready    = 1'b1;
        instr_ready       = 1'b1;
        mem_hold          = 1'b0;
        hi_redirect_valid = 1'b0;
        hi_redirect_pc    = '0;
        hi_req_ready      = 1'b1;
        hi_instr_ready    = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_pc", imem_req_addr, 32'h0);
        check("rst_hi_pc", hi_req_addr, 32'hFFFF_FFF8);
        $display("reset state: req_valid=%0b instr_valid=%0b", imem_req_valid, instr_valid);

        // Streaming fetch with ready decode
        reset = 1'b1;
        @(negedge clk);
        check("s1_req_valid", 32'(imem_req_valid), 32'd1);
        check("s1_req_addr", imem_req_addr, 32'h0);
        check("s1_instr_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("s2_req_addr", imem_req_addr, 32'h4);
        check("s2_instr_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("s3_instr_valid", 32'(instr_valid), 32'd1);
        wait_instr("s_0", 32'h0);
        wait_instr("s_4", 32'h4);
        wait_instr("s_8", 32'h8);
        wait_instr("s_c", 32'hC);
        wait_instr("s_10", 32'h10);

        // Decode stalled: credits cap requests at DEPTH
        do_reset(1'b0);
        fires = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) fires++;
        end
        check("bp_fires", 32'(fires), 32'd2);
        check("bp_req_valid", 32'(imem_req_valid), 32'd0);
        check("bp_head_pc", instr_pc, 32'h0);
        $display("backpressure: %0d requests issued", fires);
        instr_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_valid", 32'(imem_req_valid), 32'd1);
        check("bp_resume_addr", imem_req_addr, 32'h8);
        wait_instr("bp_4", 32'h4);
        wait_instr("bp_8", 32'h8);

        // Redirect with two requests outstanding
        do_reset(1'b1);
        mem_hold = 1'b1;
        repeat (3) @(negedge clk);
        check("rd_full_req_valid", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        @(negedge clk);
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        #1;
        check("rd_req_valid", 32'(imem_req_valid), 32'd0);
        check("rd_req_addr", imem_req_addr, 32'h100);
        check("rd_instr_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        wait_instr("rd_100", 32'h100);
        wait_instr("rd_104", 32'h104);

        // Redirect colliding with a response and a pop
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        check("rc_head_valid", 32'(instr_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        instr_ready    = 1'b1;
        #1;
        check("rc_req_valid_redir", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("rc_instr_valid", 32'(instr_valid), 32'd0);
        check("rc_req_valid", 32'(imem_req_valid), 32'd1);
        check("rc_req_addr", imem_req_addr, 32'h200);
        @(negedge clk);
        wait_instr("rc_200", 32'h200);

        // PC wrap from a high reset vector
        do_reset(1'b1);
        wait_hi("hi_fff8", 32'hFFFF_FFF8);
        wait_hi("hi_fffc", 32'hFFFF_FFFC);
        wait_hi("hi_0", 32'h0000_0000);

        // Reset asserted with a full queue
        do_reset(1'b0);
        repeat (6) @(negedge clk);
        check("mr_full_valid", 32'(instr_valid), 32'd1);
        check("mr_full_req", 32'(imem_req_valid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("mr_instr_valid", 32'(instr_valid), 32'd0);
        check("mr_req_valid", 32'(imem_req_valid), 32'd0);
        check("mr_pc", imem_req_addr, 32'h0);
        check("mr_instr", instr, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("mr_restart_valid", 32'(imem_req_valid), 32'd1);
        check("mr_restart_addr", imem_req_addr, 32'h0);
        $display("mid-stream reset: restart addr=%h", imem_req_addr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
